// File: rtl/jpeg_rom_reader_if.sv
// ROM fetch bus plus output byte stream of the JPEG ROM reader.
// master = reader side, slave = ROM/consumer side.
interface jpeg_rom_reader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  rom_rd_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [7:0]            rom_data;
    logic                  rom_done;
    logic [7:0]            byte_data;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  byte_last;

    modport master (
        output rom_rd_en, rom_addr,
        output byte_data, byte_valid, byte_last,
        input  rom_data, rom_done, byte_ready
    );

    modport slave (
        input  rom_rd_en, rom_addr,
        input  byte_data, byte_valid, byte_last,
        output rom_data, rom_done, byte_ready
    );
endinterface

// File: rtl/jpeg_rom_reader.sv
// Streams ROM bytes from address 0 to a valid/ready sink.
// Define JPEG_ROM_READER_EOI_DETECT_EN to stop at an FF D9 marker.
module jpeg_rom_reader #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    jpeg_rom_reader_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic [ADDR_WIDTH:0] byte_count
);
    typedef enum logic [1:0] {
        IDLE, FETCH, DRAIN, DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]            byte_data_q, byte_data_d;
    logic                  byte_valid_q, byte_valid_d;
    logic                  byte_last_q, byte_last_d;
    logic [ADDR_WIDTH:0]   byte_count_q, byte_count_d;
    logic                  load, hs, eoi, is_last, restart;

`ifdef JPEG_ROM_READER_EOI_DETECT_EN
    logic [7:0] prev_q, prev_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_q <= 8'h00;
        else      prev_q <= prev_d;
    end

    always_comb begin
        prev_d = prev_q;
        if (restart)   prev_d = 8'h00;
        else if (load) prev_d = bus.rom_data;
    end

    assign eoi = (prev_q == 8'hFF) && (bus.rom_data == 8'hD9);
`else
    assign eoi = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rom_addr_q   <= '0;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            byte_last_q  <= byte_last_d;
            byte_count_q <= byte_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start)           state_d = FETCH;
            FETCH:      if (load && is_last) state_d = DRAIN;
            DRAIN:      if (hs)              state_d = DONE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        restart = start && (state_q == IDLE || state_q == DONE);
        load    = (state_q == FETCH) && (!byte_valid_q || bus.byte_ready);
        hs      = byte_valid_q && bus.byte_ready;
        is_last = bus.rom_done || eoi;

        rom_addr_d   = rom_addr_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = byte_valid_q;
        byte_last_d  = byte_last_q;
        byte_count_d = byte_count_q + {{ADDR_WIDTH{1'b0}}, hs};

        if (restart) begin
            rom_addr_d   = '0;
            byte_valid_d = 1'b0;
            byte_last_d  = 1'b0;
            byte_count_d = '0;
        end else if (load) begin
            // hold at all-ones so the address never wraps to 0
            if (!bus.rom_done) rom_addr_d = rom_addr_q + 1'b1;
            byte_data_d  = bus.rom_data;
            byte_valid_d = 1'b1;
            byte_last_d  = is_last;
        end else if (state_q == DRAIN && hs) begin
            byte_valid_d = 1'b0;
            byte_last_d  = 1'b0;
        end
    end

    assign bus.rom_rd_en  = load;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.byte_data  = byte_data_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_last  = byte_last_q;
    assign busy           = (state_q == FETCH) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign byte_count     = byte_count_q;
endmodule

// File: tb/tb_jpeg_rom_reader.sv
// Directed bench for jpeg_rom_reader with a 16-byte ROM.
// Covers streaming, backpressure, restart, async reset and end detection.
module tb_jpeg_rom_reader;
    localparam int AW = 4;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          busy, done;
    logic [AW:0]   byte_count;
    logic [7:0]    rom [16];
    int            checks = 0;
    int            errors = 0;

    jpeg_rom_reader_if #(.ADDR_WIDTH(AW)) bus ();

    assign bus.rom_data = rom[bus.rom_addr];
    assign bus.rom_done = (bus.rom_addr == 4'hF);

    jpeg_rom_reader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rdy;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       rd;
        logic [3:0] a;
        logic [4:0] cnt;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(
        input logic rdy, input logic v, input logic [7:0] d,
        input logic l, input logic rd, input logic [3:0] a,
        input logic [4:0] cnt, input logic bsy, input logic dn
    );
        vec_t r;
        r.rdy = rdy; r.v = v; r.d = d; r.l = l; r.rd = rd;
        r.a = a; r.cnt = cnt; r.bsy = bsy; r.dn = dn;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, bus.byte_valid, 0);
        chk({tag, " last"},  bus.byte_last, 0);
        chk({tag, " rd_en"}, bus.rom_rd_en, 0);
        chk({tag, " addr"},  bus.rom_addr, 0);
        chk({tag, " data"},  bus.byte_data, 0);
        chk({tag, " count"}, byte_count, 0);
        chk({tag, " busy"},  busy, 0);
        chk({tag, " done"},  done, 0);
    endtask

    logic [7:0] got [32];
    logic [7:0] rom_b [16];
    int         n, last_idx, hs, expv, exp_n, exp_addr;
    bit         fin;

    initial begin
        bus.byte_ready = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'(i);

        #2 rst = 1'b0;
        #1 chk_zero("por");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("idle busy", busy, 0);
        chk("idle done", done, 0);
        chk("idle valid", bus.byte_valid, 0);

        tbl[0] = mk(1, 0, 8'h00, 0, 1, 0, 0, 1, 0);
        tbl[1] = mk(1, 1, 8'h00, 0, 1, 1, 0, 1, 0);
        tbl[2] = mk(1, 1, 8'h01, 0, 1, 2, 1, 1, 0);
        tbl[3] = mk(0, 1, 8'h02, 0, 0, 3, 2, 1, 0);
        tbl[4] = mk(0, 1, 8'h02, 0, 0, 3, 2, 1, 0);
        tbl[5] = mk(0, 1, 8'h02, 0, 0, 3, 2, 1, 0);
        tbl[6] = mk(1, 1, 8'h02, 0, 1, 3, 2, 1, 0);
        for (int k = 3; k <= 14; k++)
            tbl[k+4] = mk(1, 1, 8'(k), 0, 1, 4'(k + 1), 5'(k), 1, 0);
        tbl[19] = mk(1, 1, 8'h0F, 1, 0, 4'hF, 5'd15, 1, 0);
        tbl[20] = mk(1, 0, 8'h00, 0, 0, 4'hF, 5'd16, 0, 1);

        do_start();
        for (int i = 0; i < 21; i++) begin
            bus.byte_ready = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d valid", i), bus.byte_valid, tbl[i].v);
            if (tbl[i].v)
                chk($sformatf("v%0d data", i), bus.byte_data, tbl[i].d);
            chk($sformatf("v%0d last", i), bus.byte_last, tbl[i].l);
            chk($sformatf("v%0d rd_en", i), bus.rom_rd_en, tbl[i].rd);
            chk($sformatf("v%0d addr", i), bus.rom_addr, tbl[i].a);
            chk($sformatf("v%0d count", i), byte_count, tbl[i].cnt);
            chk($sformatf("v%0d busy", i), busy, tbl[i].bsy);
            chk($sformatf("v%0d done", i), done, tbl[i].dn);
            @(negedge clk);
        end

        // restart from DONE, stray start mid-stream, then async reset
        bus.byte_ready = 1'b1;
        do_start();
        #1;
        chk("rs addr", bus.rom_addr, 0);
        chk("rs count", byte_count, 0);
        chk("rs valid", bus.byte_valid, 0);
        chk("rs done", done, 0);
        chk("rs busy", busy, 1);
        hs = 0;
        expv = 0;
        for (int c = 0; c < 40 && hs < 7; c++) begin
            @(negedge clk);
            start = (hs == 3);
            #1;
            if (bus.byte_valid) begin
                chk($sformatf("seq byte%0d", expv), bus.byte_data, expv);
                expv++;
                hs++;
            end
        end
        chk("seq reached", hs, 7);
        @(negedge clk);
        start = 1'b0;
        #1 chk("seq count", byte_count, 7);
        #3 rst = 1'b0;
        #1 chk_zero("arst");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("post rst busy", busy, 0);
        do_start();
        #1;
        chk("again rd_en", bus.rom_rd_en, 1);
        chk("again addr", bus.rom_addr, 0);
        @(negedge clk);
        #1;
        chk("again valid", bus.byte_valid, 1);
        chk("again data", bus.byte_data, 8'h00);

        // ROM with an embedded FF D9 marker
        rom_b[0] = 8'hFF; rom_b[1] = 8'hD8; rom_b[2] = 8'h12;
        rom_b[3] = 8'hFF; rom_b[4] = 8'hD9;
        for (int i = 5; i < 16; i++) rom_b[i] = 8'hAA;
`ifdef JPEG_ROM_READER_EOI_DETECT_EN
        exp_n = 5;
        exp_addr = 5;
`else
        exp_n = 16;
        exp_addr = 15;
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) rom[i] = rom_b[i];
        do_start();
        n = 0;
        last_idx = -1;
        fin = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            #1;
            if (bus.byte_valid) begin
                if (n < 32) got[n] = bus.byte_data;
                if (bus.byte_last) last_idx = n;
                n++;
            end
            if (done) fin = 1'b1;
            else @(negedge clk);
        end
        chk("eoi finished", fin, 1);
        chk("eoi nbytes", n, exp_n);
        chk("eoi last idx", last_idx, exp_n - 1);
        chk("eoi count", byte_count, exp_n);
        chk("eoi addr", bus.rom_addr, exp_addr);
        for (int i = 0; i < exp_n && i < n; i++)
            chk($sformatf("eoi byte%0d", i), got[i], rom_b[i]);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
